mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; all values in this document assume WIDTH=32.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 op  input  1  0 = signed multiply, 1 = signed divide.
REQ-006 a  input  32  operand A (multiplicand / dividend), from register A.
REQ-007 b  input  32  operand B (multiplier / divisor), from register B.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 div_zero  output  1  high with done when a divide had b = 0.
REQ-011 hi  output  32  HI result register (product high word / remainder); feeds the register write-data mux.
REQ-012 lo  output  32  LO result register (product low word / quotient); feeds the register write-data mux.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DZ.
- IDLE -> RUN on start=1, except divide with b=0.
- IDLE -> DZ on start=1, op=1, b=0.
- RUN -> IDLE after the 32nd iteration.
- DZ -> IDLE unconditionally.
REQ-014 Let E0 be the edge that samples start in IDLE.
- E0: latch a, b and op; load the 6-bit iteration counter with 32.
REQ-015 Iterations:
- Edges E1..E32 each perform exactly one iteration and decrement the counter.
- At E32, hi/lo are loaded, done is set and the FSM returns to IDLE.
REQ-016 busy SHALL be high from E0 through E32 (32 cycles); low in the cycle where done is high.
REQ-017 done SHALL be registered, high for exactly one cycle after the completing edge, and otherwise 0.
REQ-018 Multiply:
- Radix-2 Booth, two's-complement.
- {hi, lo} = full 64-bit signed product of a and b; no overflow possible.
REQ-019 Divide:
- Restoring division on magnitudes |a|, |b| (33-bit internal remainder).
- Signs corrected at E32.
- Quotient truncated toward zero → lo.
- Remainder takes the sign of the dividend → hi.
REQ-020 Divide 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000 (wraps, no flag).
REQ-021 Divide with b = 0:
- E0 enters DZ.
- At E1: done = 1, div_zero = 1, hi and lo left unchanged.
REQ-022 div_zero SHALL be cleared on the next edge, and is never high without done.
REQ-023 start while busy (RUN or DZ) SHALL be ignored; changes to a, b and op after E0 SHALL not affect the running operation.
REQ-024 start=1 in the same cycle done=1 (FSM in IDLE) SHALL begin a new operation at that edge; hi/lo keep the just-written values until that operation completes.
REQ-025 hi and lo SHALL change only at a completing edge of RUN, and SHALL hold otherwise.

Reset
REQ-026 While reset = 0, the block SHALL immediately and asynchronously force:
- FSM = IDLE, counter = 0;
- busy = 0, done = 0, div_zero = 0;
- hi = 0x00000000, lo = 0x00000000;
- internal operand/partial registers = 0.
REQ-027 Reset asserted mid-operation SHALL abort it; no done pulse for the aborted operation, and hi/lo = 0.
REQ-028 After reset deasserts, the first rising edge with start = 1 SHALL be treated as E0.

Verification
REQ-029 mult a=7, b=0xFFFFFFFD:
- busy high 32 cycles;
- done 32 cycles after E0 with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-030 mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000; then div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 div a=100, b=7 (hi=lo=0x12345678 beforehand) -> lo=14, hi=2; then div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-032 div a=5, b=0 with hi=lo=0x12345678 -> done and div_zero high in cycle after E1, busy pulse 1 cycle, hi/lo stay 0x12345678.
REQ-033 mult 3*4 then pulse start with op=1, a=9, b=3 at cycle 10 -> ignored, single done, lo=12, hi=0.
REQ-034 mult 3*4 then back-to-back start coincident with done -> second op begins at that edge.
REQ-035 Reset at cycle 15 of a multiply -> busy/done/hi/lo = 0 immediately; no done pulse thereafter.

Source files
------------

// File: rtl/mult_div.sv
// rtl/mult_div.sv - iterative signed multiply (radix-2 Booth) / divide (restoring) unit
module mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DZ} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic             op_r, neg_q, neg_r, qbit;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qr, m;

  logic [WIDTH:0]   acc_nxt, booth_sum, shifted, diff;
  logic [WIDTH-1:0] qr_nxt, res_hi, res_lo, abs_a, abs_b;
  logic             qbit_nxt, last_iter;

  assign abs_a     = a[WIDTH-1] ? -a : a;
  assign abs_b     = b[WIDTH-1] ? -b : b;
  assign last_iter = (count == CW'(1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (op && b == '0) ? DZ : RUN;
      RUN:     if (last_iter) state_nxt = IDLE;
      DZ:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration: Booth uses {acc, qr, qbit}; division shifts the dividend out of qr into acc.
  always_comb begin
    acc_nxt   = acc;
    qr_nxt    = qr;
    qbit_nxt  = qbit;
    booth_sum = acc;
    shifted   = '0;
    diff      = '0;
    if (!op_r) begin
      case ({qr[0], qbit})
        2'b01:   booth_sum = acc + {m[WIDTH-1], m};
        2'b10:   booth_sum = acc - {m[WIDTH-1], m};
        default: booth_sum = acc;
      endcase
      {acc_nxt, qr_nxt, qbit_nxt} = {booth_sum[WIDTH], booth_sum, qr};
    end else begin
      shifted = {acc[WIDTH-1:0], qr[WIDTH-1]};
      diff    = shifted - {1'b0, m};
      if (diff[WIDTH]) begin
        acc_nxt = shifted;
        qr_nxt  = {qr[WIDTH-2:0], 1'b0};
      end else begin
        acc_nxt = diff;
        qr_nxt  = {qr[WIDTH-2:0], 1'b1};
      end
    end
  end

  always_comb begin
    res_hi = acc_nxt[WIDTH-1:0];
    res_lo = qr_nxt;
    if (op_r) begin
      res_lo = neg_q ? -qr_nxt : qr_nxt;
      res_hi = neg_r ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      op_r     <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      qbit     <= 1'b0;
      acc      <= '0;
      qr       <= '0;
      m        <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            count <= CW'(WIDTH);
            acc   <= '0;
            qbit  <= 1'b0;
            if (op) begin
              qr    <= abs_a;
              m     <= abs_b;
              neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_r <= a[WIDTH-1];
            end else begin
              qr    <= b;
              m     <= a;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          qr    <= qr_nxt;
          qbit  <= qbit_nxt;
          count <= count - CW'(1);
          if (last_iter) begin
            done <= 1'b1;
            hi   <= res_hi;
            lo   <= res_lo;
          end
        end
        DZ: begin
          done     <= 1'b1;
          div_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// tb/tb_mult_div.sv - scoreboard bench for mult_div
module tb_mult_div;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  mult_div #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic [5:0]  lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int          checks = 0;
  int          failures = 0;
  int          busy_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] cur_hi = '0, cur_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic; a zero divisor leaves hi/lo as they were.
  function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] ph, input logic [31:0] pl);
    exp_t   e;
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dz  = 1'b0;
    e.lat = 6'd32;
    if (!o) begin
      p    = sx * sy;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == 32'd0) begin
      e.hi  = ph;
      e.lo  = pl;
      e.dz  = 1'b1;
      e.lat = 6'd1;
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Caller is between a negedge and the next posedge with the DUT idle.
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    e = model(o, x, y, m_hi, m_lo);
    sb.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    #1;
    start = 1'b0;
    op    = 1'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 expected=1");
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (div_zero) chk("div_zero_without_done", done, 1);
      if (done) begin
        chk("busy_low_with_done", busy, 0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          me = sb.pop_front();
          chk("hi", hi, me.hi);
          chk("lo", lo, me.lo);
          chk("div_zero", div_zero, me.dz);
          chk("busy_cycles", busy_cnt, me.lat);
          cur_hi = me.hi;
          cur_lo = me.lo;
        end
        busy_cnt = 0;
      end else begin
        chk("hi_hold", hi, cur_hi);
        chk("lo_hold", lo, cur_lo);
        if (busy) busy_cnt++;
      end
    end
  end

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_done();
    chk("mul_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mul_neg_lo", lo, 32'hFFFF_FFEB);

    @(negedge clk);
    issue(1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_done();
    chk("mul_min_hi", hi, 32'h4000_0000);
    chk("mul_min_lo", lo, 32'h0000_0000);

    @(negedge clk);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    @(negedge clk);
    issue(1'b1, 32'd5, 32'd0);
    wait_done();
    chk("dz_flag", div_zero, 1);
    chk("dz_hi_kept", hi, 32'hFFFF_FFFF);
    chk("dz_lo_kept", lo, 32'hFFFF_FFFD);

    @(negedge clk);
    issue(1'b1, 32'd100, 32'd7);
    wait_done();
    chk("div_lo", lo, 32'd14);
    chk("div_hi", hi, 32'd2);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    chk("div_wrap_lo", lo, 32'h8000_0000);
    chk("div_wrap_hi", hi, 32'h0000_0000);
    chk("div_wrap_dz", div_zero, 0);

    @(negedge clk);
    issue(1'b0, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("ign_lo", lo, 32'd12);
    chk("ign_hi", hi, 32'd0);
    repeat (36) @(negedge clk);

    issue(1'b0, 32'd3, 32'd4);
    wait_done();
    issue(1'b1, 32'd9, 32'd3);
    chk("b2b_busy", busy, 1);
    wait_done();
    chk("b2b_lo", lo, 32'd3);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      issue(1'($urandom_range(0, 1)), pick(), pick());
      wait_done();
    end

    @(negedge clk);
    issue(1'b0, 32'h1234_5678, 32'h0000_0321);
    repeat (14) @(negedge clk);
    #2;
    reset = 1'b0;
    sb.delete();
    m_hi = '0; m_lo = '0; cur_hi = '0; cur_lo = '0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      issue(1'($urandom_range(0, 1)), pick(), pick());
      wait_done();
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
